// File: rtl/ftdi_pkg.sv
// Shared types and constants for the FT245 synchronous-FIFO transmit path.
package ftdi_pkg;

  localparam int unsigned CountWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StWait,
    StFlush
  } tx_state_e;

endpackage

// File: rtl/ftdi_245_tx.sv
// FT245 synchronous-FIFO write side: one-word holding register between an upstream
// FWFT FIFO and the chip, with an idle timer that issues a send-immediate pulse.
module ftdi_245_tx
  import ftdi_pkg::*;
#(
  parameter int unsigned DSIZE        = 8,
  parameter int unsigned SIWU_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DSIZE-1:0]      fifo_rdata,
  input  logic                  fifo_rempty,
  output logic                  fifo_rinc,
  input  logic                  ftdi_txe_n,
  output logic                  ftdi_wr_n,
  output logic [DSIZE-1:0]      ftdi_data,
  output logic                  ftdi_siwu_n,
  output logic [CountWidth-1:0] tx_count,
  output logic                  busy
);

  localparam logic [7:0] TimeoutCnt = 8'(SIWU_TIMEOUT);

  tx_state_e             r_state;
  tx_state_e             w_state_d;
  logic                  r_hold_valid;
  logic                  w_hold_valid_d;
  logic [DSIZE-1:0]      r_hold_data;
  logic [CountWidth-1:0] r_tx_count;
  logic [7:0]            r_idle_cnt;
  logic [7:0]            w_idle_cnt_d;
  logic [7:0]            w_idle_inc;
  logic                  r_siwu_n;
  logic                  w_siwu_n_d;
  logic [1:0]            r_startup_cnt;
  logic                  w_startup;
  logic                  w_accept;
  logic                  w_load;

  assign w_startup  = (r_startup_cnt != 2'd2);
  assign w_accept   = r_hold_valid & ~ftdi_txe_n;
  assign w_load     = enable & ~fifo_rempty & ~w_startup & (~r_hold_valid | w_accept);
  assign w_idle_inc = r_idle_cnt + 8'd1;

  // A load wins over an accept in the same cycle: the slot is refilled, not emptied.
  assign w_hold_valid_d = w_load ? 1'b1 : (w_accept ? 1'b0 : r_hold_valid);

  always_comb begin
    w_state_d    = r_state;
    w_idle_cnt_d = '0;
    case (r_state)
      StIdle:   if (w_accept) w_state_d = StActive;
      StActive: if (!w_hold_valid_d) w_state_d = StWait;
      StWait: begin
        if (w_load) begin
          w_state_d = StActive;
        end else begin
          w_idle_cnt_d = w_idle_inc;
          if (w_idle_inc == TimeoutCnt) w_state_d = StFlush;
        end
      end
      StFlush:  w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
    w_siwu_n_d = ~((w_state_d == StFlush) & ~w_hold_valid_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_hold_valid  <= 1'b0;
      r_hold_data   <= '0;
      r_tx_count    <= '0;
      r_idle_cnt    <= '0;
      r_siwu_n      <= 1'b1;
      r_startup_cnt <= '0;
    end else begin
      r_state      <= w_state_d;
      r_hold_valid <= w_hold_valid_d;
      r_idle_cnt   <= w_idle_cnt_d;
      r_siwu_n     <= w_siwu_n_d;
      if (w_load) r_hold_data <= fifo_rdata;
      if (w_accept) r_tx_count <= r_tx_count + 1'b1;
      if (w_startup) r_startup_cnt <= r_startup_cnt + 2'd1;
    end
  end

  assign fifo_rinc   = w_load;
  assign ftdi_wr_n   = ~r_hold_valid;
  assign ftdi_data   = r_hold_data;
  assign ftdi_siwu_n = r_siwu_n;
  assign tx_count    = r_tx_count;
  assign busy        = r_hold_valid | (r_state != StIdle);

endmodule
